// File: rtl/cpu_decode_stage_pkg.sv
// Shared MIPS-I opcode/funct encodings, decode FSM states and the decoded-bundle type
// for the ID stage.
package cpu_pkg;

  localparam logic [5:0]
    OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02, OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04, OP_BNE    = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ  = 6'h07,
    OP_ADDI  = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
    OP_ANDI  = 6'h0C, OP_ORI    = 6'h0D, OP_XORI = 6'h0E, OP_LUI   = 6'h0F,
    OP_LB    = 6'h20, OP_LH     = 6'h21, OP_LWL  = 6'h22, OP_LW    = 6'h23,
    OP_LBU   = 6'h24, OP_LHU    = 6'h25, OP_LWR  = 6'h26,
    OP_SB    = 6'h28, OP_SH     = 6'h29, OP_SWL  = 6'h2A, OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR = 6'h08, FN_JALR = 6'h09;
  localparam logic [4:0] RA_INDEX = 5'd31;
  localparam logic [5:0] ILLEGAL_OPCODE = 6'h3F;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_e;

  typedef struct packed {
    logic [4:0]  src_s;
    logic [4:0]  src_t;
    logic [4:0]  dest;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] imm;
    logic [25:0] target;
  } decoded_t;

  function automatic logic funct_legal(input logic [5:0] fn);
    case (fn)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0C, 6'h0D,
      6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B,
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B:
        return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_decode_stage_if.sv
// Fetch, register-file and EX-side signals of the decode stage. master = decode stage,
// slave = surrounding pipeline (fetch, regfile, EX).
interface cpu_decode_stage_if #(
  parameter int regCount = 32,
  parameter int PC_W     = 32
);
  localparam int RW = $clog2(regCount);

  logic            if_valid;
  logic [31:0]     if_instr;
  logic [PC_W-1:0] if_pc;
  logic            if_ready;
  logic [RW-1:0]   reg_s;
  logic [RW-1:0]   reg_t;
  logic [RW-1:0]   reg_id_d;
  logic            reg_stall;
  logic            flush;
  logic            ex_valid;
  logic            ex_ready;
  logic [5:0]      ex_opcode;
  logic [5:0]      ex_funct;
  logic [4:0]      ex_shamt;
  logic [31:0]     ex_imm;
  logic [25:0]     ex_target;
  logic [PC_W-1:0] ex_pc;
  logic [RW-1:0]   ex_dest;
  logic            ex_kill;

  modport master (
    input  if_valid, if_instr, if_pc, reg_stall, flush, ex_ready,
    output if_ready, reg_s, reg_t, reg_id_d, ex_valid, ex_opcode, ex_funct,
           ex_shamt, ex_imm, ex_target, ex_pc, ex_dest, ex_kill
  );

  modport slave (
    output if_valid, if_instr, if_pc, reg_stall, flush, ex_ready,
    input  if_ready, reg_s, reg_t, reg_id_d, ex_valid, ex_opcode, ex_funct,
           ex_shamt, ex_imm, ex_target, ex_pc, ex_dest, ex_kill
  );
endinterface

// File: rtl/cpu_decode_stage_fields.sv
// Combinational MIPS-I field split, immediate extension, source/dest selection and legality.
// CPU_DECODE_ILLEGAL_TRAP_EN: unknown encodings report ILLEGAL_OPCODE instead of passing through.
module cpu_instr_fields
  import cpu_pkg::*;
(
  input  logic [31:0] instr,
  output decoded_t    dec
);
  logic [5:0] op;
  logic [4:0] rs, rt, rd;
  logic [4:0] s, t, d;
  logic       legal, zext;
  logic [5:0] op_out;

  assign op = instr[31:26];
  assign rs = instr[25:21];
  assign rt = instr[20:16];
  assign rd = instr[15:11];

  // rt only counts as a source where it is really read, so no false lock stalls
  always_comb begin
    legal = 1'b1;
    zext  = 1'b0;
    s     = '0;
    t     = '0;
    d     = '0;
    case (op)
      OP_RTYPE: begin
        legal = funct_legal(instr[5:0]);
        s = rs;
        t = rt;
        d = (instr[5:0] == FN_JR) ? 5'd0 : rd;
      end
      OP_REGIMM: begin
        legal = (rt[3:1] == 3'b000);
        s = rs;
        d = rt[4] ? RA_INDEX : 5'd0;
      end
      OP_J: ;
      OP_JAL: d = RA_INDEX;
      OP_BEQ, OP_BNE: begin
        s = rs;
        t = rt;
      end
      OP_BLEZ, OP_BGTZ: s = rs;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: begin
        s = rs;
        d = rt;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        s = rs;
        d = rt;
        zext = 1'b1;
      end
      OP_LUI: begin
        d = rt;
        zext = 1'b1;
      end
      OP_SB, OP_SH, OP_SWL, OP_SW: begin
        s = rs;
        t = rt;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      s = '0;
      t = '0;
      d = '0;
    end
  end

`ifdef CPU_DECODE_ILLEGAL_TRAP_EN
  assign op_out = legal ? op : ILLEGAL_OPCODE;
`else
  assign op_out = op;
`endif

  always_comb begin
    dec.src_s  = s;
    dec.src_t  = t;
    dec.dest   = d;
    dec.opcode = op_out;
    dec.funct  = instr[5:0];
    dec.shamt  = instr[10:6];
    dec.imm    = zext ? {16'h0000, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};
    dec.target = instr[25:0];
  end
endmodule

// File: rtl/cpu_decode_stage.sv
// MIPS-I decode stage: IDLE -> ISSUE -> WAIT* -> HOLD handshake with the regfile and EX.
// Illegal-encoding behaviour selected by CPU_DECODE_ILLEGAL_TRAP_EN (see cpu_instr_fields).
module cpu_decode_stage
  import cpu_pkg::*;
#(
  parameter int regCount = 32,
  parameter int PC_W     = 32
)(
  input  logic               clock,
  input  logic               reset,
  cpu_decode_stage_if.master bus
);
  localparam int RW = $clog2(regCount);

  state_e          state_q, state_d;
  logic [31:0]     instr_q, instr_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            flush_q, flush_d;
  decoded_t        dec;
  logic            busy, flushed, has_dest;
  logic [RW-1:0]   dest_idx;

  // Decoding from the latched word keeps indices stable for the whole instruction
  cpu_instr_fields u_fields (.instr(instr_q), .dec(dec));

  assign busy     = (state_q != S_IDLE);
  assign flushed  = flush_q | bus.flush;
  assign has_dest = (dec.dest != 5'd0);
  assign dest_idx = busy ? RW'(dec.dest) : '0;

  assign bus.if_ready = (state_q == S_IDLE) && reset && !bus.flush;

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    flush_d = flush_q;
    case (state_q)
      S_IDLE: begin
        if (bus.if_valid && bus.if_ready) begin
          instr_d = bus.if_instr;
          pc_d    = bus.if_pc;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        flush_d = flushed;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        flush_d = flushed;
        if (!bus.reg_stall) begin
          // A flushed instruction with no lock to release has nothing to tell EX
          if (flushed && !has_dest) begin
            state_d = S_IDLE;
            flush_d = 1'b0;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        flush_d = flushed;
        if (bus.ex_ready || (flushed && !has_dest)) begin
          state_d = S_IDLE;
          flush_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      pc_q    <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
    end
  end

  assign bus.reg_s     = busy ? RW'(dec.src_s) : '0;
  assign bus.reg_t     = busy ? RW'(dec.src_t) : '0;
  assign bus.reg_id_d  = dest_idx;
  assign bus.ex_valid  = (state_q == S_HOLD);
  assign bus.ex_kill   = (state_q == S_HOLD) && flushed && has_dest;
  assign bus.ex_opcode = dec.opcode;
  assign bus.ex_funct  = dec.funct;
  assign bus.ex_shamt  = dec.shamt;
  assign bus.ex_imm    = dec.imm;
  assign bus.ex_target = dec.target;
  assign bus.ex_pc     = pc_q;
  assign bus.ex_dest   = dest_idx;
endmodule
